rotate_operand_stage: RTL and testbench

ROTATE_OPERAND_STAGE -- requirements
Module: rotate_operand_stage

---
 rtl/rotate_operand_stage_pkg.sv | 19 +
 rtl/rotate_operand_stage_core.sv | 34 +++
 rtl/rotate_operand_stage.sv | 131 +++++++++++++
 tb/tb_rotate_operand_stage.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rotate_operand_stage_pkg.sv
// Shared definitions for the rotate operand stage: FSM states, direction
// encoding and the default datapath geometry.
package rotate_operand_stage_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_AMT_W = 5;

  // Direction encoding as sampled on the dir input.
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HAVE_Y = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

endpackage

// File: rtl/rotate_operand_stage_core.sv
// rotate_core: stateless barrel rotate.
//   data   - value to rotate
//   amt    - rotate amount (already reduced mod WIDTH)
//   dir    - DIR_RIGHT / DIR_LEFT
//   result - rotated data
module rotate_core
  import rotate_operand_stage_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned AMT_W = DEFAULT_AMT_W
) (
  input  logic [WIDTH-1:0] data,
  input  logic [AMT_W-1:0] amt,
  input  logic             dir,
  output logic [WIDTH-1:0] result
);

  logic [AMT_W-1:0] ramt;

  // A left rotate by amt is a right rotate by (WIDTH - amt) mod WIDTH; the
  // two's complement in AMT_W bits gives exactly that, and keeps amt 0 at 0.
  always_comb begin
    ramt = amt;
    if (dir == DIR_LEFT) begin
      ramt = AMT_W'(~amt + AMT_W'(1));
    end
  end

  // Right rotate: shift the doubled word and keep the low half.
  always_comb begin
    result = WIDTH'({data, data} >> ramt);
  end

endmodule

// File: rtl/rotate_operand_stage.sv
// rotate_operand_stage: captures a data operand (Y) and a rotate amount from a
// shared bus, performs one rotate, and holds the result under a valid/ready
// handshake.
//   clk, clr_n   - clock, async active-low reset
//   bus_in       - shared operand bus
//   y_in         - capture bus_in into Y
//   op_start     - capture bus_in as amount (+ dir) and launch
//   dir          - 0 rotate right, 1 rotate left
//   z_out        - registered result
//   res_valid    - result waiting for consumer
//   res_ready    - consumer accepts result
//   busy         - operation in flight (EXEC/HOLD)
//   seq_err      - one-cycle pulse for each cycle with an ignored strobe
module rotate_operand_stage
  import rotate_operand_stage_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned AMT_W = DEFAULT_AMT_W
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             y_in,
  input  logic             op_start,
  input  logic             dir,
  output logic [WIDTH-1:0] z_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic             seq_err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             res_valid_q, res_valid_d;
  logic             busy_q, busy_d;
  logic             seq_err_q, seq_err_d;
  logic [WIDTH-1:0] rot_result;

  rotate_core #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) u_rotate_core (
    .data   (y_q),
    .amt    (amt_q),
    .dir    (dir_q),
    .result (rot_result)
  );

  // Next-state, operand capture and handshake decode.
  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    amt_d     = amt_q;
    dir_d     = dir_q;
    z_d       = z_q;
    seq_err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (y_in) begin
          y_d     = bus_in;
          state_d = ST_HAVE_Y;
        end
        // Without a fresh Y there is nothing to rotate, so op_start is dropped.
        seq_err_d = op_start;
      end
      ST_HAVE_Y: begin
        if (op_start) begin
          amt_d     = AMT_W'(bus_in);
          dir_d     = dir;
          state_d   = ST_EXEC;
          // bus_in carries the amount this cycle, so a coincident y_in is lost.
          seq_err_d = y_in;
        end else if (y_in) begin
          y_d = bus_in;
        end
      end
      ST_EXEC: begin
        z_d       = rot_result;
        state_d   = ST_HOLD;
        seq_err_d = y_in | op_start;
      end
      ST_HOLD: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
        seq_err_d = y_in | op_start;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flags are registered copies of the upcoming state.
    res_valid_d = (state_d == ST_HOLD);
    busy_d      = (state_d == ST_EXEC) || (state_d == ST_HOLD);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= ST_IDLE;
      y_q         <= '0;
      amt_q       <= '0;
      dir_q       <= DIR_RIGHT;
      z_q         <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      amt_q       <= amt_d;
      dir_q       <= dir_d;
      z_q         <= z_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      seq_err_q   <= seq_err_d;
    end
  end

  assign z_out     = z_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;
  assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_rotate_operand_stage.sv
// Self-checking bench for rotate_operand_stage (WIDTH 32).
module tb_rotate_operand_stage;

  logic        clk;
  logic        clr_n;
  logic [31:0] bus_in;
  logic        y_in;
  logic        op_start;
  logic        dir;
  logic [31:0] z_out;
  logic        res_valid;
  logic        res_ready;
  logic        busy;
  logic        seq_err;

  int unsigned checks;
  int unsigned failures;
  logic [31:0] exp_y;

  rotate_operand_stage #(
    .WIDTH (32),
    .AMT_W (5)
  ) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .bus_in    (bus_in),
    .y_in      (y_in),
    .op_start  (op_start),
    .dir       (dir),
    .z_out     (z_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy),
    .seq_err   (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference rotate written directly from the rotate definitions.
  function automatic logic [31:0] ref_rot(input logic [31:0] y, input logic [31:0] bus,
                                          input logic d);
    int unsigned a;
    logic [63:0] w;
    a = bus % 32;
    w = {32'b0, y};
    if (a == 0) return y;
    if (d) return 32'((w << a) | (w >> (32 - a)));
    return 32'((w >> a) | (w << (32 - a)));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_y(input logic [31:0] v);
    bus_in = v;
    y_in   = 1'b1;
    tick();
    y_in   = 1'b0;
    bus_in = $urandom;
    exp_y  = v;
    check_eq("load_seq_err", seq_err, 0);
    check_eq("load_busy", busy, 0);
  endtask

  // Launch from HAVE_Y; leaves the DUT in its first HOLD cycle.
  task automatic launch(input logic [31:0] amt_bus, input logic d, input logic with_y,
                        output logic [31:0] ez);
    ez       = ref_rot(exp_y, amt_bus, d);
    bus_in   = amt_bus;
    dir      = d;
    op_start = 1'b1;
    y_in     = with_y;
    tick();
    op_start = 1'b0;
    y_in     = 1'b0;
    dir      = 1'b0;
    bus_in   = $urandom;
    check_eq("exec_busy", busy, 1);
    check_eq("exec_valid", res_valid, 0);
    check_eq("exec_seq_err", seq_err, with_y);
    tick();
    check_eq("hold_valid", res_valid, 1);
    check_eq("hold_busy", busy, 1);
    check_eq("hold_z", z_out, ez);
    check_eq("hold_seq_err", seq_err, 0);
  endtask

  // Hold for 'delay' extra cycles (strobes per mask bit), then accept.
  task automatic accept(input logic [31:0] ez, input int delay, input logic [7:0] strobes);
    for (int i = 0; i < delay; i++) begin
      res_ready = 1'b0;
      bus_in    = $urandom;
      if (i % 2 == 0) y_in = strobes[i];
      else op_start = strobes[i];
      tick();
      y_in     = 1'b0;
      op_start = 1'b0;
      check_eq("stall_valid", res_valid, 1);
      check_eq("stall_z", z_out, ez);
      check_eq("stall_seq_err", seq_err, strobes[i]);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_eq("acc_valid", res_valid, 0);
    check_eq("acc_busy", busy, 0);
    check_eq("acc_z_kept", z_out, ez);
    check_eq("acc_seq_err", seq_err, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_z"}, z_out, 0);
    check_eq({tag, "_valid"}, res_valid, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_seq_err"}, seq_err, 0);
  endtask

  // op_start alone must be rejected when IDLE.
  task automatic idle_op_start();
    bus_in   = 32'd5;
    op_start = 1'b1;
    tick();
    op_start = 1'b0;
    check_eq("idle_op_seq_err", seq_err, 1);
    check_eq("idle_op_busy", busy, 0);
    check_eq("idle_op_valid", res_valid, 0);
    tick();
    check_eq("idle_op_seq_err_clr", seq_err, 0);
    check_eq("idle_op_valid2", res_valid, 0);
  endtask

  initial begin
    logic [31:0] ez;
    checks    = 0;
    failures  = 0;
    exp_y     = '0;
    clr_n     = 1'b0;
    bus_in    = '0;
    y_in      = 1'b0;
    op_start  = 1'b0;
    dir       = 1'b0;
    res_ready = 1'b0;
    #12;
    check_all_zero("reset");
    clr_n = 1'b1;
    tick();
    check_all_zero("post_reset");

    // Test 1: right rotate by 1.
    load_y(32'h8000_0001);
    launch(32'd1, 1'b0, 1'b0, ez);
    check_eq("t1_z", ez, 32'hC000_0000);
    accept(ez, 0, 8'h00);

    // Test 2: left rotate by 4, then amount 36 (same mod 32); reload in HAVE_Y.
    load_y(32'hFFFF_0000);
    load_y(32'h1234_5678);
    launch(32'd4, 1'b1, 1'b0, ez);
    check_eq("t2a_z", ez, 32'h2345_6781);
    accept(ez, 1, 8'h00);
    load_y(32'h1234_5678);
    launch(32'd36, 1'b1, 1'b0, ez);
    check_eq("t2b_z", ez, 32'h2345_6781);
    accept(ez, 0, 8'h00);

    // Test 3: amount 0 both directions.
    load_y(32'hA5A5_A5A5);
    launch(32'd0, 1'b0, 1'b0, ez);
    check_eq("t3r_z", ez, 32'hA5A5_A5A5);
    accept(ez, 0, 8'h00);
    load_y(32'hA5A5_A5A5);
    launch(32'd32, 1'b1, 1'b0, ez);
    check_eq("t3l_z", ez, 32'hA5A5_A5A5);
    accept(ez, 0, 8'h00);

    // Test 4: 5-cycle stall with a y_in pulse mid-HOLD.
    load_y(32'h0000_00F1);
    launch(32'd8, 1'b0, 1'b0, ez);
    accept(ez, 5, 8'b0000_0100);

    // Test 5: op_start in IDLE, then both strobes together in HAVE_Y.
    idle_op_start();
    load_y(32'h0F0F_00FF);
    launch(32'd8, 1'b0, 1'b1, ez);
    check_eq("t5_z", ez, 32'hFF0F_0F00);
    accept(ez, 0, 8'h00);

    // Test 6: reset during EXEC.
    load_y(32'hDEAD_BEEF);
    bus_in   = 32'd3;
    dir      = 1'b1;
    op_start = 1'b1;
    tick();
    op_start = 1'b0;
    check_eq("t6_exec_busy", busy, 1);
    clr_n = 1'b0;
    #1;
    check_all_zero("t6_rst_exec");
    #3;
    clr_n = 1'b1;
    tick();
    check_all_zero("t6_rel_exec");
    idle_op_start();

    // Test 6: reset during HOLD.
    load_y(32'h1357_9BDF);
    launch(32'd12, 1'b1, 1'b0, ez);
    clr_n = 1'b0;
    #1;
    check_all_zero("t6_rst_hold");
    #3;
    clr_n = 1'b1;
    tick();
    check_all_zero("t6_rel_hold");
    tick();
    check_eq("t6_no_valid", res_valid, 0);
    load_y(32'h8765_4321);
    launch(32'd7, 1'b0, 1'b0, ez);
    accept(ez, 2, 8'h00);

    // Randomized operations.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] rv;
      logic [31:0] ra;
      logic        rd;
      logic        both;
      int          dl;
      logic [7:0]  mk;
      rv   = $urandom;
      ra   = $urandom;
      rd   = 1'($urandom_range(0, 1));
      both = ($urandom_range(0, 3) == 0);
      dl   = $urandom_range(0, 4);
      mk   = 8'($urandom);
      load_y(rv);
      launch(ra, rd, both, ez);
      accept(ez, dl, mk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
